// File: rtl/cmos_power_cfg_ctrl.sv
// Power-up sequencer and dual-bus I2C register initialiser for two OV5640 cameras.
// Both buses are open-drain and always carry the same drive; an entry advances only once both slaves ACK every byte.
`timescale 1ns/1ps
module cmos_power_cfg_ctrl #(
    parameter int          PWDN_DLY = 50000,
    parameter int          RST_DLY  = 13000,
    parameter int          INIT_DLY = 210000,
    parameter int          CLK_DIV  = 125,
    parameter int          REG_NUM  = 252,
    parameter logic [7:0]  DEV_ADDR = 8'h78
) (
    input  logic        clk_10M,
    input  logic        rst_n,
    output logic        cmos_pwdn,
    output logic        cmos_rstn,
    output logic        initial_en,
    output logic [8:0]  reg_index,
    input  logic [23:0] reg_data,
    inout  wire         i2c_scl1,
    inout  wire         i2c_scl2,
    inout  wire         i2c_sda1,
    inout  wire         i2c_sda2,
    output logic        cmos_init_done
);

    localparam logic [31:0] C_PWDN_END = 32'(PWDN_DLY - 1);
    localparam logic [31:0] C_RST_END  = 32'(PWDN_DLY + RST_DLY - 1);
    localparam logic [31:0] C_INIT_END = 32'(PWDN_DLY + RST_DLY + INIT_DLY - 1);
    localparam logic [15:0] C_DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [8:0]  C_LAST     = 9'(REG_NUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_STOP, S_GAP, S_DONE} state_t;

    logic [31:0] r_pwr_cnt;
    logic        r_pwdn, r_rstn, r_init_en;
    logic [15:0] r_div;
    logic        w_tick;

    state_t      r_state, w_state_next;
    logic [1:0]  r_q, w_q_next;
    logic [3:0]  r_bit, w_bit_next;
    logic [1:0]  r_byte, w_byte_next;
    logic [31:0] r_shift, w_shift_next;
    logic        r_nack, w_nack_next;
    logic [8:0]  r_index, w_index_next;
    logic        r_done, w_done_next;
    logic        r_scl_low, r_sda_low, w_scl_low_next, w_sda_low_next;
    logic [1:0]  r_sda_meta, r_sda_sync;
    logic        w_sda_high;

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_cnt <= 32'd0;
            r_pwdn    <= 1'b1;
            r_rstn    <= 1'b0;
            r_init_en <= 1'b0;
        end else if (!r_init_en) begin
            r_pwr_cnt <= r_pwr_cnt + 32'd1;
            if (r_pwr_cnt == C_PWDN_END) r_pwdn    <= 1'b0;
            if (r_pwr_cnt == C_RST_END)  r_rstn    <= 1'b1;
            if (r_pwr_cnt == C_INIT_END) r_init_en <= 1'b1;
        end
    end

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 16'd0;
        end else if (!r_init_en || r_div == C_DIV_LAST) begin
            r_div <= 16'd0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    assign w_tick = r_init_en && (r_div == C_DIV_LAST);

    // SDA comes from off-chip slaves; resynchronise before the ACK decision.
    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_meta <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_sda_meta <= {i2c_sda2, i2c_sda1};
            r_sda_sync <= r_sda_meta;
        end
    end

    assign w_sda_high = r_sda_sync[0] | r_sda_sync[1];

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_q       <= 2'd0;
            r_bit     <= 4'd0;
            r_byte    <= 2'd0;
            r_shift   <= 32'd0;
            r_nack    <= 1'b0;
            r_index   <= 9'd0;
            r_done    <= 1'b0;
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_q       <= w_q_next;
            r_bit     <= w_bit_next;
            r_byte    <= w_byte_next;
            r_shift   <= w_shift_next;
            r_nack    <= w_nack_next;
            r_index   <= w_index_next;
            r_done    <= w_done_next;
            r_scl_low <= w_scl_low_next;
            r_sda_low <= w_sda_low_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;
        w_nack_next  = r_nack;
        w_index_next = r_index;
        w_done_next  = r_done;
        if (w_tick) begin
            w_q_next = r_q + 2'd1;
            case (r_state)
                S_IDLE: begin
                    w_q_next = 2'd0;
                    if (!r_done) begin
                        w_state_next = S_START;
                        w_shift_next = {DEV_ADDR, reg_data};
                        w_nack_next  = 1'b0;
                    end
                end
                S_START: begin
                    if (r_q == 2'd3) begin
                        w_state_next = S_BYTE;
                        w_bit_next   = 4'd0;
                        w_byte_next  = 2'd0;
                    end
                end
                S_BYTE: begin
                    // Bit 8 is the ACK slot; sample mid-high.
                    if (r_q == 2'd2 && r_bit == 4'd8) w_nack_next = w_sda_high;
                    if (r_q == 2'd3) begin
                        if (r_bit != 4'd8) begin
                            w_shift_next = {r_shift[30:0], 1'b0};
                            w_bit_next   = r_bit + 4'd1;
                        end else if (r_nack || r_byte == 2'd3) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_byte_next = r_byte + 2'd1;
                            w_bit_next  = 4'd0;
                        end
                    end
                end
                S_STOP: begin
                    if (r_q == 2'd3) w_state_next = S_GAP;
                end
                S_GAP: begin
                    // Return through IDLE so the next capture sees reg_data for the updated index.
                    if (r_q == 2'd3) begin
                        w_state_next = S_IDLE;
                        if (!r_nack) begin
                            if (r_index == C_LAST) begin
                                w_state_next = S_DONE;
                                w_done_next  = 1'b1;
                            end else begin
                                w_index_next = r_index + 9'd1;
                            end
                        end
                    end
                end
                S_DONE: w_q_next = 2'd0;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_scl_low_next = 1'b0;
        w_sda_low_next = 1'b0;
        case (w_state_next)
            S_START: begin
                w_scl_low_next = w_q_next[1];
                w_sda_low_next = (w_q_next != 2'd0);
            end
            S_BYTE: begin
                w_scl_low_next = (w_q_next == 2'd0) || (w_q_next == 2'd3);
                w_sda_low_next = (w_bit_next != 4'd8) && !w_shift_next[31];
            end
            S_STOP: begin
                w_scl_low_next = (w_q_next == 2'd0);
                w_sda_low_next = !w_q_next[1];
            end
            default: ;
        endcase
    end

    assign i2c_scl1 = r_scl_low ? 1'b0 : 1'bz;
    assign i2c_scl2 = r_scl_low ? 1'b0 : 1'bz;
    assign i2c_sda1 = r_sda_low ? 1'b0 : 1'bz;
    assign i2c_sda2 = r_sda_low ? 1'b0 : 1'bz;

    assign cmos_pwdn      = r_pwdn;
    assign cmos_rstn      = r_rstn;
    assign initial_en     = r_init_en;
    assign reg_index      = r_index;
    assign cmos_init_done = r_done;

endmodule

// File: tb/tb_cmos_power_cfg_ctrl.sv
// Self-checking bench: two ACKing I2C slaves with a frame decoder feeding a scoreboard.
`timescale 1ns/1ps
module tb_cmos_power_cfg_ctrl;

    typedef struct {
        int          n;
        logic [31:0] data;
    } frame_t;

    logic        clk_10M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cmos_pwdn, cmos_rstn, initial_en, cmos_init_done;
    logic [8:0]  reg_index;
    logic [23:0] reg_data;
    wire         scl1, scl2, sda1, sda2;
    logic        ack_low1 = 1'b0;
    logic        ack_low2 = 1'b0;
    logic [23:0] tbl [0:2];

    int checks   = 0;
    int failures = 0;

    frame_t obs_q[$];
    frame_t exp_q[$];

    bit          nack_armed = 1'b0;
    bit          in_frame   = 1'b0;
    bit          p_scl      = 1'b1;
    bit          p_sda      = 1'b1;
    int          bit_cnt    = 0;
    int          cur_n      = 0;
    logic [7:0]  sh         = 8'h00;
    logic [31:0] cur_data   = 32'h0;
    int          scl_edges  = 0;
    int          bus_diff   = 0;

    pullup (scl1);
    pullup (scl2);
    pullup (sda1);
    pullup (sda2);
    assign sda1 = ack_low1 ? 1'b0 : 1'bz;
    assign sda2 = ack_low2 ? 1'b0 : 1'bz;

    assign reg_data = (reg_index < 9'd3) ? tbl[reg_index[1:0]] : 24'h0;

    always #50 clk_10M = ~clk_10M;

    cmos_power_cfg_ctrl #(
        .PWDN_DLY (10),
        .RST_DLY  (5),
        .INIT_DLY (20),
        .CLK_DIV  (2),
        .REG_NUM  (3),
        .DEV_ADDR (8'h78)
    ) dut (
        .clk_10M        (clk_10M),
        .rst_n          (rst_n),
        .cmos_pwdn      (cmos_pwdn),
        .cmos_rstn      (cmos_rstn),
        .initial_en     (initial_en),
        .reg_index      (reg_index),
        .reg_data       (reg_data),
        .i2c_scl1       (scl1),
        .i2c_scl2       (scl2),
        .i2c_sda1       (sda1),
        .i2c_sda2       (sda2),
        .cmos_init_done (cmos_init_done)
    );

    // Bus monitor and slave model: decodes bus 1, ACKs on both buses unless a bus-2 NACK is armed.
    always @(negedge clk_10M) begin
        frame_t f;
        if (!rst_n) begin
            in_frame = 1'b0;
            bit_cnt  = 0;
            cur_n    = 0;
            ack_low1 = 1'b0;
            ack_low2 = 1'b0;
        end else begin
            if (scl1 !== scl2) bus_diff++;
            if (ack_low1 == ack_low2 && sda1 !== sda2) bus_diff++;
            if (p_scl && scl1 && p_sda && !sda1) begin
                in_frame = 1'b1;
                bit_cnt  = 0;
                cur_n    = 0;
                cur_data = 32'h0;
            end else if (p_scl && scl1 && !p_sda && sda1) begin
                if (in_frame) begin
                    f.n    = cur_n;
                    f.data = cur_data;
                    obs_q.push_back(f);
                end
                in_frame = 1'b0;
            end else if (!p_scl && scl1) begin
                scl_edges++;
                if (bit_cnt < 8) begin
                    sh = {sh[6:0], sda1};
                    bit_cnt++;
                end else begin
                    bit_cnt = 9;
                end
            end else if (p_scl && !scl1) begin
                scl_edges++;
                if (bit_cnt == 8 && in_frame) begin
                    ack_low1 = 1'b1;
                    ack_low2 = !(nack_armed && cur_n == 1);
                    if (!ack_low2) nack_armed = 1'b0;
                end else if (bit_cnt == 9) begin
                    ack_low1 = 1'b0;
                    ack_low2 = 1'b0;
                    cur_data = {cur_data[23:0], sh};
                    cur_n++;
                    bit_cnt  = 0;
                end
            end
        end
        p_scl = scl1;
        p_sda = sda1;
    end

    task automatic wait_frame(output frame_t f, output bit ok);
        ok  = 1'b0;
        f.n = 0;
        f.data = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_10M);
            if (obs_q.size() > 0) begin
                f  = obs_q.pop_front();
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_10M);
        #1;
        checks++; if (cmos_pwdn !== 1'b1) begin failures++; $display("FAIL reset_pwdn got=%b exp=1", cmos_pwdn); end
        checks++; if (cmos_rstn !== 1'b0) begin failures++; $display("FAIL reset_rstn got=%b exp=0", cmos_rstn); end
        checks++; if (initial_en !== 1'b0) begin failures++; $display("FAIL reset_initial_en got=%b exp=0", initial_en); end
        checks++; if (cmos_init_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", cmos_init_done); end
        checks++; if (reg_index !== 9'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", reg_index); end
        checks++; if ({scl1, sda1, scl2, sda2} !== 4'hF) begin failures++; $display("FAIL reset_lines got=%b exp=1111", {scl1, sda1, scl2, sda2}); end
        $display("reset: pwdn=%b rstn=%b init_en=%b lines=%b", cmos_pwdn, cmos_rstn, initial_en, {scl1, sda1, scl2, sda2});
    endtask

    task automatic test_power_up();
        logic [2:0] exp;
        @(negedge clk_10M);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_10M);
            #1;
            exp = {(k < 10), (k >= 15), (k >= 35)};
            checks++;
            if ({cmos_pwdn, cmos_rstn, initial_en} !== exp) begin
                failures++;
                $display("FAIL power_seq cycle=%0d got=%b exp=%b", k, {cmos_pwdn, cmos_rstn, initial_en}, exp);
            end
            if (k < 35) begin
                checks++;
                if ({scl1, sda1, scl2, sda2} !== 4'hF) begin
                    failures++;
                    $display("FAIL power_lines cycle=%0d got=%b exp=1111", k, {scl1, sda1, scl2, sda2});
                end
            end
        end
        $display("power_up: pwdn=%b rstn=%b init_en=%b", cmos_pwdn, cmos_rstn, initial_en);
    endtask

    task automatic test_nack_retry();
        frame_t e, f;
        bit ok;
        nack_armed = 1'b1;
        e.n = 2; e.data = 32'h0000_7830;            exp_q.push_back(e);
        e.n = 4; e.data = {8'h78, tbl[0]};          exp_q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            wait_frame(f, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL nack_frame%0d timeout got=none exp=%0d bytes %h", i, e.n, e.data);
            end else if (f.n != e.n || f.data !== e.data) begin
                failures++;
                $display("FAIL nack_frame%0d got=%0d bytes %h exp=%0d bytes %h", i, f.n, f.data, e.n, e.data);
            end
            $display("frame: idx=%0d bytes=%0d data=%h", reg_index, f.n, f.data);
            checks++;
            if (reg_index !== 9'd0) begin failures++; $display("FAIL nack_index_hold%0d got=%0d exp=0", i, reg_index); end
        end
        repeat (20) @(posedge clk_10M);
        #1;
        checks++; if (reg_index !== 9'd1) begin failures++; $display("FAIL nack_index_inc got=%0d exp=1", reg_index); end
    endtask

    task automatic test_table_walk();
        frame_t e, f;
        bit ok;
        for (int i = 1; i <= 2; i++) begin
            e.n = 4; e.data = {8'h78, tbl[i]}; exp_q.push_back(e);
        end
        for (int i = 1; i <= 2; i++) begin
            wait_frame(f, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL walk_frame%0d timeout got=none exp=%h", i, e.data);
            end else if (f.n != e.n || f.data !== e.data) begin
                failures++;
                $display("FAIL walk_frame%0d got=%0d bytes %h exp=%0d bytes %h", i, f.n, f.data, e.n, e.data);
            end
            $display("frame: idx=%0d bytes=%0d data=%h", reg_index, f.n, f.data);
            checks++;
            if (cmos_init_done !== 1'b0) begin failures++; $display("FAIL walk_done_early%0d got=%b exp=0", i, cmos_init_done); end
        end
        repeat (20) @(posedge clk_10M);
        #1;
        checks++; if (cmos_init_done !== 1'b1) begin failures++; $display("FAIL walk_done got=%b exp=1", cmos_init_done); end
        checks++; if (reg_index !== 9'd2) begin failures++; $display("FAIL walk_index_final got=%0d exp=2", reg_index); end
    endtask

    task automatic test_done_quiet();
        int e0;
        e0 = scl_edges;
        repeat (1000) @(posedge clk_10M);
        #1;
        checks++; if (scl_edges != e0) begin failures++; $display("FAIL done_scl_edges got=%0d exp=%0d", scl_edges, e0); end
        checks++; if ({scl1, sda1, scl2, sda2} !== 4'hF) begin failures++; $display("FAIL done_lines got=%b exp=1111", {scl1, sda1, scl2, sda2}); end
        checks++; if ({cmos_init_done, reg_index} !== {1'b1, 9'd2}) begin failures++; $display("FAIL done_hold got=%b/%0d exp=1/2", cmos_init_done, reg_index); end
        $display("done_quiet: edges=%0d done=%b idx=%0d", scl_edges, cmos_init_done, reg_index);
    endtask

    task automatic test_reset_mid_frame();
        frame_t e, f;
        bit ok, hit;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_10M);
        @(negedge clk_10M);
        rst_n = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_10M);
            if (in_frame && cur_n == 2 && bit_cnt >= 3) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL midrst_reach_byte3 got=timeout exp=third byte"); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({cmos_pwdn, cmos_rstn, initial_en, cmos_init_done} !== 4'b1000) begin failures++; $display("FAIL midrst_ctrl got=%b exp=1000", {cmos_pwdn, cmos_rstn, initial_en, cmos_init_done}); end
        checks++; if (reg_index !== 9'd0) begin failures++; $display("FAIL midrst_index got=%0d exp=0", reg_index); end
        checks++; if ({scl1, sda1, scl2, sda2} !== 4'hF) begin failures++; $display("FAIL midrst_lines got=%b exp=1111", {scl1, sda1, scl2, sda2}); end
        repeat (2) @(posedge clk_10M);
        @(negedge clk_10M);
        rst_n = 1'b1;
        e.n = 4; e.data = {8'h78, tbl[0]}; exp_q.push_back(e);
        wait_frame(f, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrst_frame0 timeout got=none exp=%h", e.data);
        end else if (f.n != e.n || f.data !== e.data) begin
            failures++;
            $display("FAIL midrst_frame0 got=%0d bytes %h exp=%0d bytes %h", f.n, f.data, e.n, e.data);
        end
        $display("frame: idx=%0d bytes=%0d data=%h (after restart)", reg_index, f.n, f.data);
        repeat (20) @(posedge clk_10M);
        #1;
        checks++; if (reg_index !== 9'd1) begin failures++; $display("FAIL midrst_index_inc got=%0d exp=1", reg_index); end
    endtask

    task automatic test_bus_match();
        checks++; if (bus_diff != 0) begin failures++; $display("FAIL bus_identical got=%0d diffs exp=0", bus_diff); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL spurious_frames got=%0d exp=0", obs_q.size()); end
        $display("bus_match: diffs=%0d leftover=%0d", bus_diff, obs_q.size());
    endtask

    initial begin
        tbl[0] = 24'h300811;
        tbl[1] = 24'h3103A5;
        tbl[2] = 24'h4740C3;
        test_reset();
        test_power_up();
        test_nack_retry();
        test_table_walk();
        test_done_quiet();
        test_reset_mid_frame();
        test_bus_match();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmos_power_cfg_ctrl.md
Name: cmos_power_cfg_ctrl

Overview:
- Power-up sequencer plus I2C register initialiser for two OV5640 cameras, all in the clk_10M domain.
- Sequences power-down release, reset release and the init-enable delay.
- Then writes REG_NUM register entries (16-bit address, 8-bit data) to both cameras simultaneously over two identical open-drain I2C buses.
- Register table is external, read combinationally via reg_index; cmos_init_done gates downstream pixel packing.

Parameters:
- PWDN_DLY, 50000: clk cycles from reset release to cmos_pwdn deassert (5 ms).
- RST_DLY, 13000: further cycles until cmos_rstn release (1.3 ms).
- INIT_DLY, 210000: further cycles until initial_en asserts (21 ms).
- CLK_DIV, 125: clk cycles per I2C quarter-bit tick (4 ticks/bit gives 20 kHz SCL).
- REG_NUM, 252: number of table entries to write.
- DEV_ADDR, 8'h78: 8-bit I2C write address.

Ports:
- clk_10M  in  1  10 MHz clock
- rst_n  in  1  asynchronous active-low reset
- cmos_pwdn  out  1  camera power-down, high = powered down
- cmos_rstn  out  1  camera reset, low = reset
- initial_en  out  1  power sequence complete
- reg_index  out  9  current table entry
- reg_data  in  24  {reg_addr[15:0], reg_val[7:0]} for reg_index
- i2c_scl1, i2c_scl2  inout  1  open-drain SCL
- i2c_sda1, i2c_sda2  inout  1  open-drain SDA
- cmos_init_done  out  1  all entries written and acknowledged

Behaviour:
- Reset (async, rst_n=0) values:
  - cmos_pwdn=1, cmos_rstn=0, initial_en=0, cmos_init_done=0, reg_index=0.
  - SCL and SDA released (Z); all counters 0.
- Power sequence:
  - A counter runs from reset release.
  - cmos_pwdn falls after PWDN_DLY cycles.
  - cmos_rstn rises RST_DLY cycles after that.
  - initial_en rises INIT_DLY cycles after that.
  - All three are sticky until reset.
- Open-drain rule: a line is either driven 0 or left Z, never driven 1. Both buses always carry identical drive values.
- Tick: a pulse every CLK_DIV cycles, free-running once initial_en=1. The FSM advances only on ticks.
- Bit timing, 4 ticks per bit:
  - q0: SCL low, update SDA.
  - q1: SCL released.
  - q2: SCL high; sample SDA for ACK.
  - q3: SCL low.
- FSM states: IDLE, START, BYTE (8 data bits + ACK bit), STOP, GAP, DONE.
  - IDLE → START when initial_en=1 and cmos_init_done=0.
  - START: SDA falls while SCL is high, then SCL falls.
  - Then four bytes, MSB first: DEV_ADDR, reg_data[23:16], reg_data[15:8], reg_data[7:0].
  - During each ACK bit SDA is released.
  - STOP: SDA rises while SCL is high.
  - GAP: 4 ticks idle with both lines released.
- reg_data is captured into a shift register at START. Table changes mid-transfer have no effect.
- ACK check: NACK if either sda1 or sda2 reads 1 at an ACK sample.
  - On NACK: abort the rest of the frame, go to STOP then GAP, and retry the same reg_index.
  - There is no retry limit.
- On a fully acknowledged frame: after GAP, reg_index increments.
  - If reg_index was REG_NUM-1, go to DONE instead and set cmos_init_done=1.
- DONE: lines released, cmos_init_done held at 1, reg_index frozen at REG_NUM-1, no further bus activity until reset.
- A reset mid-frame releases the buses at once; the whole power and config sequence restarts from the beginning.

Test Plan:
- Power-up sequence (PWDN_DLY=10, RST_DLY=5, INIT_DLY=20): release reset → cmos_pwdn falls at cycle 10, cmos_rstn rises at cycle 15, initial_en rises at cycle 35. I2C lines stay Z before initial_en.
- Single frame (REG_NUM=1, CLK_DIV=2, reg_data=24'h300811, bench slave always ACKs) → decoded bytes 0x78, 0x30, 0x08, 0x11. START and STOP occur with SCL high. cmos_init_done rises after GAP; reg_index stays 0.
- Table walk (REG_NUM=3, always ACK) → exactly 3 frames, for reg_index 0, 1, 2 in that order. cmos_init_done=1 afterwards; no further SCL edges.
- NACK retry (NACK only on the first frame's second byte, on bus 2 only) → frame aborts with STOP and the same entry is resent. reg_index increments only after the full ACK; done after REG_NUM good frames.
- Open-drain check: throughout, neither SCL nor SDA is ever driven 1. Both buses show identical waveforms.
- Reset mid-frame (rst_n low during the third byte) → all outputs return to reset values immediately. Sequence restarts and frame 0 is rewritten.
